// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder load/store responder.
package mem_resp_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned WORD_LSB = 2;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x 32 word storage: one byte-masked synchronous write port and two
// asynchronous read ports (access path and debug/test path).
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   wen,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_t,
  output logic [DATA_W-1:0] rdata_t
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; contents survive a responder reset and map to plain RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BE_W); b++) begin
      if (wen[b]) begin
        mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_t = mem_q[raddr_t];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed load/store responder with LATENCY wait cycles between accept and response.
// Build option: define MEM_RESP_ERR_EN to flag and suppress out-of-range accesses via resp_err.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BE_W-1:0]   req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic [ADDR_W-1:0] test_addr,
  output logic [DATA_W-1:0] test_data
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned HI_LSB = IDX_W + WORD_LSB;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [BE_W-1:0]   wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              exec;
  logic [BE_W-1:0]   acc_wen;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] rd_word;
  logic              hi_set;
  logic              oor;
  logic              unused_bits;

  // With LATENCY=0 the access executes on the accept edge, straight from the request inputs.
  assign acc_wen   = (state_q == ST_IDLE) ? req_wen   : wen_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  assign hi_set = |acc_addr[ADDR_W-1:HI_LSB];

`ifdef MEM_RESP_ERR_EN
  assign oor         = hi_set;
  assign unused_bits = ^{acc_addr[WORD_LSB-1:0], test_addr[ADDR_W-1:HI_LSB],
                         test_addr[WORD_LSB-1:0]};
`else
  assign oor         = 1'b0;
  assign unused_bits = ^{hi_set, acc_addr[WORD_LSB-1:0], test_addr[ADDR_W-1:HI_LSB],
                         test_addr[WORD_LSB-1:0]};
`endif

  mem_resp_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .wen     ((exec && !oor) ? acc_wen : '0),
    .waddr   (acc_addr[HI_LSB-1:WORD_LSB]),
    .wdata   (acc_wdata),
    .raddr_a (acc_addr[HI_LSB-1:WORD_LSB]),
    .rdata_a (rd_word),
    .raddr_t (test_addr[HI_LSB-1:WORD_LSB]),
    .rdata_t (test_data)
  );

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY);
          ready_d = 1'b0;
          if (LATENCY == 0) begin
            exec    = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          exec    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // Stores and rejected accesses answer with zero data.
    if (exec) begin
      err_d   = oor;
      rdata_d = (oor || acc_wen != '0) ? '0 : rd_word;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with LATENCY=2 (index 0) and one with LATENCY=0 (index 1),
// each checked against a word-array reference model.
module tb_mem_responder;

  localparam int DEPTH = 32;
  localparam int LAT0  = 2;
  localparam int LAT1  = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [3:0]  req_wen    [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [31:0] test_addr  [2];
  logic [31:0] test_data  [2];

  logic [31:0] mem_m [2][DEPTH];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .test_addr(test_addr[0]), .test_data(test_data[0])
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .test_addr(test_addr[1]), .test_data(test_data[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic oor_f(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
    return a >= 32'(DEPTH * 4);
`else
    return (a != a);
`endif
  endfunction

  function automatic int idx_f(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] merge_f(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] wen);
    logic [31:0] mask;
    mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete request/response with optional response stall and held req_valid.
  task automatic txn(input int d, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input int stall, input bit hold,
                     output logic [31:0] rd_seen);
    int n, lat, idx;
    logic [31:0] exp_rd;
    logic exp_err;
    idx     = idx_f(addr);
    exp_err = oor_f(addr);
    exp_rd  = (exp_err || wen != 4'h0) ? 32'h0 : mem_m[d][idx];
    rd_seen = 32'hx;
    req_wen[d] = wen; req_addr[d] = addr; req_wdata[d] = wdata; test_addr[d] = addr;
    resp_ready[d] = 1'b0; req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout dut%0d req_ready=%b required=1", d, req_ready[d]);
      req_valid[d] = 1'b0;
    end else begin
      step();
      if (!hold) req_valid[d] = 1'b0;
      if (lat_of(d) > 0) begin
        checks++;
        if (test_data[d] !== mem_m[d][idx]) begin
          failures++;
          $display("FAIL test_data_before_exec dut%0d addr=%h got=%h required=%h",
                   d, addr, test_data[d], mem_m[d][idx]);
        end
      end
      lat = 1;
      while (resp_valid[d] !== 1'b1 && lat < 40) begin
        checks++;
        if (req_ready[d] !== 1'b0) begin
          failures++;
          $display("FAIL ready_in_wait dut%0d got=%b required=0", d, req_ready[d]);
        end
        step();
        lat++;
      end
      if (!exp_err && wen != 4'h0) mem_m[d][idx] = merge_f(mem_m[d][idx], wdata, wen);
      checks++;
      if (lat != lat_of(d) + 1) begin
        failures++;
        $display("FAIL latency dut%0d got=%0d required=%0d", d, lat, lat_of(d) + 1);
      end
      checks++;
      if (resp_rdata[d] !== exp_rd) begin
        failures++;
        $display("FAIL rdata dut%0d addr=%h wen=%h got=%h required=%h",
                 d, addr, wen, resp_rdata[d], exp_rd);
      end
      checks++;
      if (resp_err[d] !== exp_err) begin
        failures++;
        $display("FAIL resp_err dut%0d addr=%h got=%b required=%b", d, addr, resp_err[d], exp_err);
      end
      checks++;
      if (test_data[d] !== mem_m[d][idx]) begin
        failures++;
        $display("FAIL test_data_after_exec dut%0d addr=%h got=%h required=%h",
                 d, addr, test_data[d], mem_m[d][idx]);
      end
      rd_seen = resp_rdata[d];
      for (int s = 0; s < stall; s++) begin
        step();
        checks++;
        if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== exp_rd || resp_err[d] !== exp_err ||
            req_ready[d] !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold dut%0d cyc=%0d valid=%b rdata=%h err=%b ready=%b required=1/%h/%b/0",
                   d, s, resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d], exp_rd, exp_err);
        end
      end
      resp_ready[d] = 1'b1;
      step();
      resp_ready[d] = 1'b0;
      req_valid[d]  = 1'b0;
      checks++;
      if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL handshake_done dut%0d valid=%b ready=%b required=0/1",
                 d, resp_valid[d], req_ready[d]);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'h0 ||
          resp_err[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d ready=%b valid=%b rdata=%h err=%b required=1/0/0/0",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
      end
    end
  endtask

  task automatic init_mem();
    logic [31:0] rd;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) txn(d, 4'hF, 32'(i * 4), 32'h0, 0, 1'b0, rd);
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      txn(d, 4'hF, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd);
      txn(d, 4'h0, 32'h10, 32'h0, 0, 1'b0, rd);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL basic_load dut%0d got=%h required=deadbeef", d, rd);
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      txn(d, 4'hF, 32'h08, 32'h11223344, 0, 1'b0, rd);
      txn(d, 4'b0010, 32'h08, 32'h0000AA00, 0, 1'b0, rd);
      txn(d, 4'h0, 32'h08, 32'h0, 0, 1'b0, rd);
      checks++;
      if (rd !== 32'h1122AA44) begin
        failures++;
        $display("FAIL partial_load dut%0d got=%h required=1122aa44", d, rd);
      end
      test_addr[d] = 32'h08;
      #1;
      checks++;
      if (test_data[d] !== 32'h1122AA44) begin
        failures++;
        $display("FAIL partial_test_port dut%0d got=%h required=1122aa44", d, test_data[d]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      txn(d, 4'h0, 32'h08, 32'h0, 5, 1'b1, rd);
      txn(d, 4'hC, 32'h14, 32'hA5A50000, 5, 1'b1, rd);
    end
  endtask

  // Drives one request up to the point of acceptance and leaves req_valid low afterwards.
  task automatic accept_only(input int d, input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int n;
    req_wen[d] = wen; req_addr[d] = addr; req_wdata[d] = wdata; resp_ready[d] = 1'b0;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin step(); n++; end
    step();
    req_valid[d] = 1'b0;
  endtask

  task automatic pulse_reset_check(input string tag);
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0) begin
      failures++;
      $display("FAIL %s dut0 ready=%b valid=%b rdata=%h required=1/0/0",
               tag, req_ready[0], resp_valid[0], resp_rdata[0]);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int n;
    txn(0, 4'hF, 32'h04, 32'h0, 0, 1'b0, rd);
    accept_only(0, 4'hF, 32'h04, 32'hCAFEF00D);
    checks++;
    if (resp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait_setup dut0 valid=%b required=0", resp_valid[0]);
    end
    pulse_reset_check("reset_in_wait");
    txn(0, 4'h0, 32'h04, 32'h0, 0, 1'b0, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_discard_write dut0 got=%h required=00000000", rd);
    end
    accept_only(0, 4'hF, 32'h0C, 32'h13579BDF);
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 20) begin step(); n++; end
    mem_m[0][3] = 32'h13579BDF;
    pulse_reset_check("reset_in_resp");
    txn(0, 4'h0, 32'h0C, 32'h0, 0, 1'b0, rd);
    checks++;
    if (rd !== 32'h13579BDF) begin
      failures++;
      $display("FAIL reset_keep_write dut0 got=%h required=13579bdf", rd);
    end
  endtask

  task automatic test_back_to_back(input int d, input int n);
    logic [31:0] exp_q [$];
    logic [31:0] a, rd, exp_rd;
    logic acc, rv;
    int cyc, last, accepted, got;
    cyc = 0; last = -1; accepted = 0; got = 0;
    a = 32'($urandom_range(0, DEPTH - 1) * 4);
    req_wen[d] = 4'h0; req_addr[d] = a; resp_ready[d] = 1'b1; req_valid[d] = 1'b1;
    while (got < n && cyc < 200) begin
      acc = req_valid[d] & req_ready[d];
      rv  = resp_valid[d];
      rd  = resp_rdata[d];
      step();
      cyc++;
      if (rv) begin
        exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (rd !== exp_rd) begin
          failures++;
          $display("FAIL b2b_rdata dut%0d got=%h required=%h", d, rd, exp_rd);
        end
        got++;
      end
      if (acc) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != lat_of(d) + 2) begin
            failures++;
            $display("FAIL b2b_interval dut%0d got=%0d required=%0d", d, cyc - last, lat_of(d) + 2);
          end
        end
        last = cyc;
        exp_q.push_back(mem_m[d][idx_f(a)]);
        accepted++;
        if (accepted == n) req_valid[d] = 1'b0;
        else begin
          a = 32'($urandom_range(0, DEPTH - 1) * 4);
          req_addr[d] = a;
        end
      end
    end
    req_valid[d] = 1'b0; resp_ready[d] = 1'b0;
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL b2b_timeout dut%0d got=%0d required=%0d", d, got, n);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd, exp0;
    for (int d = 0; d < 2; d++) begin
      txn(d, 4'hF, 32'h80, 32'h5A5A5A5A, 0, 1'b0, rd);
`ifdef MEM_RESP_ERR_EN
      exp0 = mem_m[d][0];
`else
      exp0 = 32'h5A5A5A5A;
`endif
      txn(d, 4'h0, 32'h00, 32'h0, 0, 1'b0, rd);
      checks++;
      if (rd !== exp0) begin
        failures++;
        $display("FAIL alias_word0 dut%0d got=%h required=%h", d, rd, exp0);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] rd, addr;
    logic [3:0] wen;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0:       wen = 4'h0;
          1:       wen = 4'hF;
          default: wen = 4'($urandom);
        endcase
        addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
        txn(d, wen, addr, $urandom, $urandom_range(0, 3), 1'($urandom), rd);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 4'h0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
      resp_ready[d] = 1'b0; test_addr[d] = 32'h0;
    end
    #3;
    test_reset();
    #4;
    reset = 1'b0;
    step();
    init_mem();
    test_basic();
    test_partial();
    test_stall();
    test_reset_mid();
    test_back_to_back(1, 8);
    test_back_to_back(0, 6);
    test_alias();
    test_random(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
